// File: rtl/apu_reg_bank_pkg.sv
// Shared constants for the APU pulse register front end: register offsets,
// the length-counter load table and the per-channel register grouping.
package apu_reg_bank_pkg;

   // Register offsets relative to $4000.
   localparam logic [4:0] REG_P1_CTRL  = 5'h00;
   localparam logic [4:0] REG_P1_SWEEP = 5'h01;
   localparam logic [4:0] REG_P1_LO    = 5'h02;
   localparam logic [4:0] REG_P1_HI    = 5'h03;
   localparam logic [4:0] REG_P2_CTRL  = 5'h04;
   localparam logic [4:0] REG_P2_SWEEP = 5'h05;
   localparam logic [4:0] REG_P2_LO    = 5'h06;
   localparam logic [4:0] REG_P2_HI    = 5'h07;
   localparam logic [4:0] REG_STATUS   = 5'h15;

   // Bit position of the length-halt flag inside $4000/$4004.
   localparam int HALT_BIT = 5;

   // Length counter load values, indexed by bits [7:3] of $4003/$4007.
   localparam logic [7:0] LEN_TABLE [32] = '{
      8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
      8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
      8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
      8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
   };

   // The four bytes that make up one pulse channel's register set.
   typedef struct packed {
      logic [7:0] ctrl;   // duty / halt / volume
      logic [7:0] sweep;
      logic [7:0] lo;     // period low byte
      logic [7:0] hi;     // length index / period high bits
   } pulse_regs_t;

   // Look up the load value for a 5-bit length index.
   function automatic logic [7:0] len_lookup(input logic [4:0] idx);
      return LEN_TABLE[idx];
   endfunction

endpackage

// File: rtl/apu_reg_bank_if.sv
// CPU-side register bus between the bus adapter and the APU register bank.
//
// Handshake: a write is a single-cycle cpu_we pulse with cpu_addr/cpu_wdata
// valid in the same cycle; a read is a single-cycle cpu_re pulse answered
// exactly one cycle later by a single-cycle cpu_rvalid with cpu_rdata. There
// is no ready/backpressure: the slave accepts one access every cycle. When
// cpu_we and cpu_re coincide the write wins and no cpu_rvalid is returned.
interface apu_reg_bank_if;
   logic [4:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic       cpu_we;
   logic       cpu_re;
   logic [7:0] cpu_rdata;
   logic       cpu_rvalid;

   modport master (
      output cpu_addr, cpu_wdata, cpu_we, cpu_re,
      input  cpu_rdata, cpu_rvalid
   );

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
      output cpu_rdata, cpu_rvalid
   );
endinterface

// File: rtl/apu_reg_bank_length_counter.sv
// One pulse channel's 8-bit length counter. Clearing the enable wins over
// everything, then a table load, then a half-frame decrement. The counter
// saturates at zero.
module apu_reg_bank_length_counter
   import apu_reg_bank_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,      // channel enable as it will be after this edge
   input  logic       load,        // $4003/$4007 write this cycle
   input  logic [4:0] load_idx,
   input  logic       halt,        // registered halt flag, before any same-cycle write
   input  logic       half_frame,
   output logic [7:0] count
);

   // Count register: disable clears, load overrides a coincident tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 8'd0;
      end else if (!enable) begin
         count <= 8'd0;
      end else if (load) begin
         count <= len_lookup(load_idx);
      end else if (half_frame && !halt && (count != 8'd0)) begin
         count <= count - 8'd1;
      end
   end

endmodule

// File: rtl/apu_reg_bank.sv
// CPU-facing register bank for the two APU pulse channels: decodes writes to
// $4000-$4007 and $4015, holds the channel register bytes, issues restart
// strobes, owns both length counters and answers $4015 status reads.
module apu_reg_bank
   import apu_reg_bank_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   apu_reg_bank_if.slave bus,
   input  logic        half_frame,
   output logic [7:0]  r4000,
   output logic [7:0]  r4001,
   output logic [7:0]  r4002,
   output logic [7:0]  r4003,
   output logic [7:0]  r4004,
   output logic [7:0]  r4005,
   output logic [7:0]  r4006,
   output logic [7:0]  r4007,
   output logic        p1_restart,
   output logic        p2_restart,
   output logic        p1_active,
   output logic        p2_active
);

   pulse_regs_t p1_regs;
   pulse_regs_t p2_regs;
   logic [1:0]  en_q;
   logic [1:0]  en_next;
   logic        wr_status;
   logic        wr_p1_hi;
   logic        wr_p2_hi;
   logic        wr_pulse;
   logic        rd_req;
   logic [7:0]  p1_len;
   logic [7:0]  p2_len;

   // Address decode; a write in the same cycle as a read suppresses the read.
   always_comb begin
      wr_status = bus.cpu_we && (bus.cpu_addr == REG_STATUS);
      wr_p1_hi  = bus.cpu_we && (bus.cpu_addr == REG_P1_HI);
      wr_p2_hi  = bus.cpu_we && (bus.cpu_addr == REG_P2_HI);
      wr_pulse  = bus.cpu_we && (bus.cpu_addr[4:3] == 2'b00);
      rd_req    = bus.cpu_re && !bus.cpu_we;
      en_next   = wr_status ? bus.cpu_wdata[1:0] : en_q;
   end

   // Pulse register storage for offsets 0x00-0x07.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1_regs <= '0;
         p2_regs <= '0;
      end else if (wr_pulse) begin
         case (bus.cpu_addr)
            REG_P1_CTRL:  p1_regs.ctrl  <= bus.cpu_wdata;
            REG_P1_SWEEP: p1_regs.sweep <= bus.cpu_wdata;
            REG_P1_LO:    p1_regs.lo    <= bus.cpu_wdata;
            REG_P1_HI:    p1_regs.hi    <= bus.cpu_wdata;
            REG_P2_CTRL:  p2_regs.ctrl  <= bus.cpu_wdata;
            REG_P2_SWEEP: p2_regs.sweep <= bus.cpu_wdata;
            REG_P2_LO:    p2_regs.lo    <= bus.cpu_wdata;
            REG_P2_HI:    p2_regs.hi    <= bus.cpu_wdata;
            default:      ;
         endcase
      end
   end

   // Channel enables from $4015 bits [1:0].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q <= 2'b00;
      end else begin
         en_q <= en_next;
      end
   end

   // Restart strobes: high for the single cycle after a $4003/$4007 write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1_restart <= 1'b0;
         p2_restart <= 1'b0;
      end else begin
         p1_restart <= wr_p1_hi;
         p2_restart <= wr_p2_hi;
      end
   end

   // Read response: status uses the counters as they were before this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.cpu_rvalid <= 1'b0;
         bus.cpu_rdata  <= 8'h00;
      end else begin
         bus.cpu_rvalid <= rd_req;
         if (rd_req && (bus.cpu_addr == REG_STATUS)) begin
            bus.cpu_rdata <= {6'b000000, (p2_len != 8'd0), (p1_len != 8'd0)};
         end else begin
            bus.cpu_rdata <= 8'h00;
         end
      end
   end

   apu_reg_bank_length_counter u_len_p1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (en_next[0]),
      .load       (wr_p1_hi),
      .load_idx   (bus.cpu_wdata[7:3]),
      .halt       (p1_regs.ctrl[HALT_BIT]),
      .half_frame (half_frame),
      .count      (p1_len)
   );

   apu_reg_bank_length_counter u_len_p2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (en_next[1]),
      .load       (wr_p2_hi),
      .load_idx   (bus.cpu_wdata[7:3]),
      .halt       (p2_regs.ctrl[HALT_BIT]),
      .half_frame (half_frame),
      .count      (p2_len)
   );

   assign r4000 = p1_regs.ctrl;
   assign r4001 = p1_regs.sweep;
   assign r4002 = p1_regs.lo;
   assign r4003 = p1_regs.hi;
   assign r4004 = p2_regs.ctrl;
   assign r4005 = p2_regs.sweep;
   assign r4006 = p2_regs.lo;
   assign r4007 = p2_regs.hi;

   assign p1_active = (p1_len != 8'd0);
   assign p2_active = (p2_len != 8'd0);

endmodule

// File: tb/tb_apu_reg_bank.sv
// Self-checking bench for apu_reg_bank: directed scenarios followed by
// randomized bus traffic, all compared every cycle against a behavioural model.
module tb_apu_reg_bank;

   logic       clk;
   logic       rst_n;
   logic       half_frame;
   logic [7:0] r4000, r4001, r4002, r4003, r4004, r4005, r4006, r4007;
   logic       p1_restart, p2_restart, p1_active, p2_active;
   logic [7:0] dut_r [8];

   apu_reg_bank_if bus ();

   apu_reg_bank dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.slave),
      .half_frame (half_frame),
      .r4000      (r4000),
      .r4001      (r4001),
      .r4002      (r4002),
      .r4003      (r4003),
      .r4004      (r4004),
      .r4005      (r4005),
      .r4006      (r4006),
      .r4007      (r4007),
      .p1_restart (p1_restart),
      .p2_restart (p2_restart),
      .p1_active  (p1_active),
      .p2_active  (p2_active)
   );

   assign dut_r[0] = r4000;
   assign dut_r[1] = r4001;
   assign dut_r[2] = r4002;
   assign dut_r[3] = r4003;
   assign dut_r[4] = r4004;
   assign dut_r[5] = r4005;
   assign dut_r[6] = r4006;
   assign dut_r[7] = r4007;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- scoreboard counters ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         len_tab [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                                12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};
   logic [7:0] m_regs [8];
   bit         m_en [2];
   int         m_len [2];
   bit         m_restart [2];
   bit         m_rvalid;
   logic [7:0] m_rdata;

   logic       s_we, s_re, s_hf;
   logic [4:0] s_a;
   logic [7:0] s_d;
   int         old_len [2];
   bit         new_en;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
         for (int c = 0; c < 2; c++) begin
            m_en[c] = 0;
            m_len[c] = 0;
            m_restart[c] = 0;
         end
         m_rvalid = 0;
         m_rdata = 8'h00;
      end else begin
         s_we = bus.cpu_we;
         s_re = bus.cpu_re;
         s_a  = bus.cpu_addr;
         s_d  = bus.cpu_wdata;
         s_hf = half_frame;
         old_len[0] = m_len[0];
         old_len[1] = m_len[1];
         // read response from pre-edge lengths
         m_rvalid = s_re && !s_we;
         m_rdata = 8'h00;
         if (m_rvalid && s_a == 5'h15) begin
            m_rdata[0] = (old_len[0] != 0);
            m_rdata[1] = (old_len[1] != 0);
         end
         for (int c = 0; c < 2; c++) begin
            m_restart[c] = s_we && (s_a == 5'(3 + 4 * c));
            new_en = (s_we && s_a == 5'h15) ? s_d[c] : m_en[c];
            if (!new_en) m_len[c] = 0;
            else if (m_restart[c]) m_len[c] = len_tab[s_d[7:3]];
            else if (s_hf && old_len[c] > 0 && !m_regs[4 * c][5]) m_len[c] = old_len[c] - 1;
            m_en[c] = new_en;
         end
         if (s_we && s_a < 5'd8) m_regs[s_a[2:0]] = s_d;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(posedge clk or negedge rst_n) begin
      #2;
      check("rvalid", {31'd0, bus.cpu_rvalid}, {31'd0, m_rvalid});
      if (m_rvalid) check("rdata", {24'd0, bus.cpu_rdata}, {24'd0, m_rdata});
      for (int i = 0; i < 8; i++) check($sformatf("r400%0d", i), {24'd0, dut_r[i]}, {24'd0, m_regs[i]});
      check("p1_restart", {31'd0, p1_restart}, {31'd0, m_restart[0]});
      check("p2_restart", {31'd0, p2_restart}, {31'd0, m_restart[1]});
      check("p1_active", {31'd0, p1_active}, {31'd0, (m_len[0] != 0)});
      check("p2_active", {31'd0, p2_active}, {31'd0, (m_len[1] != 0)});
   end

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      bus.cpu_we = 1'b0;
      bus.cpu_re = 1'b0;
      bus.cpu_addr = 5'h00;
      bus.cpu_wdata = 8'h00;
      half_frame = 1'b0;
   endtask

   // One bus cycle: drive, take the edge, return 1 time unit after it.
   task automatic cyc(input logic we, input logic re, input logic [4:0] a,
                      input logic [7:0] d, input logic hf);
      bus.cpu_we = we;
      bus.cpu_re = re;
      bus.cpu_addr = a;
      bus.cpu_wdata = d;
      half_frame = hf;
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      cyc(1'b1, 1'b0, a, d, 1'b0);
   endtask

   task automatic rd(input logic [4:0] a);
      cyc(1'b0, 1'b1, a, 8'h00, 1'b0);
   endtask

   task automatic tick();
      cyc(1'b0, 1'b0, 5'h00, 8'h00, 1'b1);
   endtask

   // Assert reset mid-cycle and confirm every output clears without a clock edge.
   task automatic async_reset_check(input string tag);
      #3;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) check($sformatf("%s_rst_r400%0d", tag, i), {24'd0, dut_r[i]}, 32'd0);
      check({tag, "_rst_act"}, {30'd0, p2_active, p1_active}, 32'd0);
      check({tag, "_rst_rstr"}, {30'd0, p2_restart, p1_restart}, 32'd0);
      check({tag, "_rst_rvalid"}, {31'd0, bus.cpu_rvalid}, 32'd0);
      check({tag, "_rst_rdata"}, {24'd0, bus.cpu_rdata}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   logic       r_we, r_re, r_hf;
   logic [4:0] r_a;
   logic [7:0] r_d;
   int         op, k;

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // reset state and first status read
      rd(5'h15);
      check("reset_rvalid", {31'd0, bus.cpu_rvalid}, 32'd1);
      check("reset_rdata", {24'd0, bus.cpu_rdata}, 32'h00);
      for (int i = 0; i < 8; i++) check($sformatf("reset_r400%0d", i), {24'd0, dut_r[i]}, 32'd0);

      // enable pulse 1, load index 1
      wr(5'h15, 8'h01);
      wr(5'h03, 8'h08);
      check("load_r4003", {24'd0, r4003}, 32'h08);
      check("load_restart", {31'd0, p1_restart}, 32'd1);
      check("model_len254", m_len[0], 32'd254);
      rd(5'h15);
      check("restart_drop", {31'd0, p1_restart}, 32'd0);
      check("status_p1", {24'd0, bus.cpu_rdata}, 32'h01);

      // index 0 -> 10, count it down to zero
      wr(5'h00, 8'h00);
      wr(5'h03, 8'h00);
      check("model_len10", m_len[0], 32'd10);
      repeat (9) tick();
      check("nine_ticks_active", {31'd0, p1_active}, 32'd1);
      tick();
      check("ten_ticks_active", {31'd0, p1_active}, 32'd0);
      tick();
      check("eleven_ticks_len", m_len[0], 32'd0);
      check("eleven_ticks_active", {31'd0, p1_active}, 32'd0);

      // halt holds the count, disable clears it
      wr(5'h03, 8'h00);
      wr(5'h00, 8'h20);
      repeat (5) tick();
      check("halt_len", m_len[0], 32'd10);
      check("halt_active", {31'd0, p1_active}, 32'd1);
      wr(5'h15, 8'h00);
      check("disable_active", {31'd0, p1_active}, 32'd0);
      rd(5'h15);
      check("disable_status", {24'd0, bus.cpu_rdata}, 32'h00);

      // write to disabled pulse 2
      wr(5'h07, 8'hF8);
      check("dis_r4007", {24'd0, r4007}, 32'hF8);
      check("dis_p2_restart", {31'd0, p2_restart}, 32'd1);
      check("dis_p2_active", {31'd0, p2_active}, 32'd0);

      // load coincident with half_frame
      wr(5'h00, 8'h00);
      wr(5'h15, 8'h03);
      cyc(1'b1, 1'b0, 5'h03, 8'h08, 1'b1);
      check("load_vs_tick", m_len[0], 32'd254);
      tick();
      check("after_tick", m_len[0], 32'd253);

      // write and read in the same cycle
      cyc(1'b1, 1'b1, 5'h15, 8'h03, 1'b0);
      check("we_re_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);

      // mid-countdown asynchronous reset
      wr(5'h07, 8'h00);
      repeat (3) tick();
      check("pre_reset_act", {30'd0, p2_active, p1_active}, 32'd3);
      async_reset_check("dir");

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) async_reset_check("rnd");
         op = $urandom_range(0, 99);
         r_we = (op < 40);
         r_re = (op >= 40 && op < 60) || (op < 3);
         k = $urandom_range(0, 9);
         if (k < 7) r_a = 5'($urandom_range(0, 7));
         else if (k < 9) r_a = 5'h15;
         else r_a = 5'($urandom_range(0, 23));
         r_d = 8'($urandom_range(0, 255));
         if (r_a == 5'h15 && $urandom_range(0, 9) < 8) r_d = 8'h03;
         r_hf = ($urandom_range(0, 2) == 0);
         cyc(r_we, r_re, r_a, r_d, r_hf);
      end

      repeat (2) @(posedge clk);
      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
